// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: two per-requester write FIFOs feeding one registered
// regfile write port through a round-robin arbiter, with combinational
// read-after-write hazard flags for two read addresses.
module rf_wr_arbiter #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid0,
  input  logic [4:0]  wa0,
  input  logic [31:0] din0,
  output logic        ready0,
  input  logic        valid1,
  input  logic [4:0]  wa1,
  input  logic [31:0] din1,
  output logic        ready1,
  output logic        we,
  output logic [4:0]  wa,
  output logic [31:0] din,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic        busy1,
  output logic        busy2
);

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned EW = AW + DW;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned NQ = 2;

  logic [EW-1:0] mem_q    [NQ][DEPTH];
  logic [EW-1:0] mem_d    [NQ][DEPTH];
  logic [PW-1:0] wr_ptr_q [NQ];
  logic [PW-1:0] wr_ptr_d [NQ];
  logic [PW-1:0] rd_ptr_q [NQ];
  logic [PW-1:0] rd_ptr_d [NQ];
  logic [CW-1:0] cnt_q    [NQ];
  logic [CW-1:0] cnt_d    [NQ];
  logic          last_grant_q, last_grant_d;
  logic          we_q, we_d;
  logic [AW-1:0] wa_q, wa_d;
  logic [DW-1:0] din_q, din_d;

  logic [NQ-1:0] in_valid;
  logic [EW-1:0] in_ent [NQ];
  logic [NQ-1:0] not_full;
  logic [NQ-1:0] non_empty;
  logic [NQ-1:0] push;
  logic [NQ-1:0] pop;
  logic          gnt0, gnt1;
  logic [EW-1:0] head;
  logic [PW-1:0] slot_off;
  logic          match1, match2;

  // Requester view: queue occupancy flags and accepted pushes
  always_comb begin
    in_valid  = {valid1, valid0};
    in_ent[0] = {wa0, din0};
    in_ent[1] = {wa1, din1};
    not_full  = '0;
    non_empty = '0;
    for (int q = 0; q < NQ; q++) begin
      not_full[q]  = (cnt_q[q] != CW'(DEPTH));
      non_empty[q] = (cnt_q[q] != '0);
    end
    push = in_valid & not_full;
  end

  // Round-robin grant: on a tie, serve the queue not granted last
  always_comb begin
    gnt1 = non_empty[1] && (!non_empty[0] || !last_grant_q);
    gnt0 = non_empty[0] && !gnt1;
    pop  = {gnt1, gnt0};
  end

  // Queue storage, pointer and count next-state
  always_comb begin
    mem_d = mem_q;
    for (int q = 0; q < NQ; q++) begin
      wr_ptr_d[q] = wr_ptr_q[q];
      rd_ptr_d[q] = rd_ptr_q[q];
      cnt_d[q]    = cnt_q[q];
      if (push[q]) begin
        mem_d[q][wr_ptr_q[q]] = in_ent[q];
        wr_ptr_d[q]           = wr_ptr_q[q] + PW'(1);
      end
      if (pop[q]) begin
        rd_ptr_d[q] = rd_ptr_q[q] + PW'(1);
      end
      case ({push[q], pop[q]})
        2'b10:   cnt_d[q] = cnt_q[q] + CW'(1);
        2'b01:   cnt_d[q] = cnt_q[q] - CW'(1);
        default: cnt_d[q] = cnt_q[q];
      endcase
    end
  end

  // Output stage: load granted head; register 0 writes are suppressed
  always_comb begin
    head         = gnt1 ? mem_q[1][rd_ptr_q[1]] : mem_q[0][rd_ptr_q[0]];
    we_d         = 1'b0;
    wa_d         = wa_q;
    din_d        = din_q;
    last_grant_d = last_grant_q;
    if (gnt0 || gnt1) begin
      we_d         = (head[EW-1:DW] != '0);
      wa_d         = head[EW-1:DW];
      din_d        = head[DW-1:0];
      last_grant_d = gnt1;
    end
  end

  // Hazard scan over live queue slots (offset from read pointer < count)
  always_comb begin
    match1   = 1'b0;
    match2   = 1'b0;
    slot_off = '0;
    for (int q = 0; q < NQ; q++) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slot_off = PW'(i) - rd_ptr_q[q];
        if (CW'(slot_off) < cnt_q[q]) begin
          if (mem_q[q][i][EW-1:DW] == ra1) match1 = 1'b1;
          if (mem_q[q][i][EW-1:DW] == ra2) match2 = 1'b1;
        end
      end
    end
  end

  // Control state with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int q = 0; q < NQ; q++) begin
        wr_ptr_q[q] <= '0;
        rd_ptr_q[q] <= '0;
        cnt_q[q]    <= '0;
      end
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      wa_q         <= '0;
      din_q        <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      wa_q         <= wa_d;
      din_q        <= din_d;
    end
  end

  // Queue payload storage; contents are only meaningful under the counts
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign ready0 = !rst && not_full[0];
  assign ready1 = !rst && not_full[1];
  assign we     = we_q;
  assign wa     = wa_q;
  assign din    = din_q;
  assign busy1  = !rst && (ra1 != '0) && (match1 || (we_q && (wa_q == ra1)));
  assign busy2  = !rst && (ra2 != '0) && (match2 || (we_q && (wa_q == ra2)));

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Bench for rf_wr_arbiter: directed scenarios plus a randomized run
// checked against a queue-based reference model.
module tb_rf_wr_arbiter;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid0, valid1;
  logic [4:0]  wa0, wa1;
  logic [31:0] din0, din1;
  logic        ready0, ready1;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] din;
  logic [4:0]  ra1, ra2;
  logic        busy1, busy2;

  int n_vec = 0;
  int n_err = 0;

  rf_wr_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .valid0(valid0), .wa0(wa0), .din0(din0), .ready0(ready0),
    .valid1(valid1), .wa1(wa1), .din1(din1), .ready1(ready1),
    .we(we), .wa(wa), .din(din),
    .ra1(ra1), .ra2(ra2), .busy1(busy1), .busy2(busy2)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    valid0 = 1'b0; wa0 = '0; din0 = '0;
    valid1 = 1'b0; wa1 = '0; din1 = '0;
    ra1 = '0; ra2 = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; idle_inputs();
    @(posedge clk); @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    valid0 = 1'b1; wa0 = 5'd3; din0 = 32'h1111_1111;
    valid1 = 1'b1; wa1 = 5'd4; din1 = 32'h2222_2222;
    ra1 = 5'd3; ra2 = 5'd4;
    @(posedge clk); @(negedge clk);
    n_vec++; if (ready0 !== 1'b0) begin n_err++; $display("FAIL reset_ready0 got %b exp 0", ready0); end
    n_vec++; if (ready1 !== 1'b0) begin n_err++; $display("FAIL reset_ready1 got %b exp 0", ready1); end
    n_vec++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL reset_busy1 got %b exp 0", busy1); end
    n_vec++; if (busy2 !== 1'b0) begin n_err++; $display("FAIL reset_busy2 got %b exp 0", busy2); end
    n_vec++; if (we !== 1'b0) begin n_err++; $display("FAIL reset_we got %b exp 0", we); end
    n_vec++; if (wa !== 5'd0) begin n_err++; $display("FAIL reset_wa got %0d exp 0", wa); end
    n_vec++; if (din !== 32'd0) begin n_err++; $display("FAIL reset_din got %h exp 0", din); end
    rst = 1'b0; valid0 = 1'b0; valid1 = 1'b0;
    #1;
    n_vec++; if (ready0 !== 1'b1) begin n_err++; $display("FAIL post_reset_ready0 got %b exp 1", ready0); end
    n_vec++; if (ready1 !== 1'b1) begin n_err++; $display("FAIL post_reset_ready1 got %b exp 1", ready1); end
    n_vec++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL reset_push_ignored_busy got %b exp 0", busy1); end
    @(posedge clk); @(negedge clk);
    n_vec++; if (we !== 1'b0) begin n_err++; $display("FAIL reset_push_ignored_we got %b exp 0", we); end
  endtask

  task automatic test_single_write();
    @(negedge clk);
    valid0 = 1'b1; wa0 = 5'd5; din0 = 32'hDEAD_BEEF; ra1 = 5'd5; ra2 = 5'd6;
    @(posedge clk); @(negedge clk);
    valid0 = 1'b0;
    n_vec++; if (we !== 1'b0) begin n_err++; $display("FAIL single_we_early got %b exp 0", we); end
    n_vec++; if (busy1 !== 1'b1) begin n_err++; $display("FAIL single_busy1_queued got %b exp 1", busy1); end
    n_vec++; if (busy2 !== 1'b0) begin n_err++; $display("FAIL single_busy2 got %b exp 0", busy2); end
    @(posedge clk); @(negedge clk);
    n_vec++; if (we !== 1'b1) begin n_err++; $display("FAIL single_we got %b exp 1", we); end
    n_vec++; if (wa !== 5'd5) begin n_err++; $display("FAIL single_wa got %0d exp 5", wa); end
    n_vec++; if (din !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL single_din got %h exp deadbeef", din); end
    n_vec++; if (busy1 !== 1'b1) begin n_err++; $display("FAIL single_busy1_out got %b exp 1", busy1); end
    @(posedge clk); @(negedge clk);
    n_vec++; if (we !== 1'b0) begin n_err++; $display("FAIL single_we_after got %b exp 0", we); end
    n_vec++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL single_busy1_clear got %b exp 0", busy1); end
    n_vec++; if (wa !== 5'd5) begin n_err++; $display("FAIL single_wa_hold got %0d exp 5", wa); end
  endtask

  task automatic test_contention();
    int i0, i1, seen, first_c, last_c;
    logic acc0, acc1;
    logic [4:0] exp_wa [8];
    logic [31:0] exp_d;
    exp_wa = '{5'd1, 5'd11, 5'd2, 5'd12, 5'd3, 5'd13, 5'd4, 5'd14};
    i0 = 0; i1 = 0; seen = 0; first_c = -1; last_c = -1;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      valid0 = (i0 < 4); wa0 = 5'(i0 + 1);  din0 = 32'hA000_0000 + 32'(i0);
      valid1 = (i1 < 4); wa1 = 5'(i1 + 11); din1 = 32'hB000_0000 + 32'(i1);
      #1;
      acc0 = valid0 && ready0; acc1 = valid1 && ready1;
      @(posedge clk);
      if (acc0) i0++;
      if (acc1) i1++;
      @(negedge clk);
      if (we === 1'b1 && seen < 8) begin
        exp_d = (exp_wa[seen] < 5'd11) ? 32'hA000_0000 + 32'(exp_wa[seen] - 5'd1)
                                       : 32'hB000_0000 + 32'(exp_wa[seen] - 5'd11);
        n_vec++; if (wa !== exp_wa[seen]) begin n_err++; $display("FAIL contention_wa[%0d] got %0d exp %0d", seen, wa, exp_wa[seen]); end
        n_vec++; if (din !== exp_d) begin n_err++; $display("FAIL contention_din[%0d] got %h exp %h", seen, din, exp_d); end
        if (first_c < 0) first_c = c;
        last_c = c;
        seen++;
      end
    end
    idle_inputs();
    n_vec++; if (seen !== 8) begin n_err++; $display("FAIL contention_count got %0d exp 8", seen); end
    n_vec++; if (last_c - first_c !== 7) begin n_err++; $display("FAIL contention_gapfree span got %0d exp 7", last_c - first_c); end
  endtask

  task automatic test_backpressure();
    int i0, i1, s0, s1;
    logic acc0, acc1;
    i0 = 0; i1 = 0; s0 = 0; s1 = 0;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      valid0 = (i0 < 6); wa0 = 5'd7;          din0 = 32'h7000_0000 + 32'(i0);
      valid1 = (i1 < 3); wa1 = 5'(20 + i1);   din1 = 32'hC000_0000 + 32'(i1);
      #1;
      acc0 = valid0 && ready0; acc1 = valid1 && ready1;
      @(posedge clk);
      if (acc0) i0++;
      if (acc1) i1++;
      @(negedge clk);
      if (c == 1) begin
        n_vec++; if (ready1 !== 1'b0) begin n_err++; $display("FAIL bp_ready1_full got %b exp 0", ready1); end
      end
      if (c == 2) begin
        n_vec++; if (ready1 !== 1'b1) begin n_err++; $display("FAIL bp_ready1_after_pop got %b exp 1", ready1); end
      end
      if (we === 1'b1 && wa >= 5'd20) begin
        n_vec++; if (wa !== 5'(20 + s1) || din !== 32'hC000_0000 + 32'(s1)) begin
          n_err++; $display("FAIL bp_req1_order[%0d] got %0d/%h exp %0d/%h", s1, wa, din, 20 + s1, 32'hC000_0000 + 32'(s1));
        end
        s1++;
      end else if (we === 1'b1) begin
        n_vec++; if (wa !== 5'd7 || din !== 32'h7000_0000 + 32'(s0)) begin
          n_err++; $display("FAIL bp_req0_order[%0d] got %0d/%h exp 7/%h", s0, wa, din, 32'h7000_0000 + 32'(s0));
        end
        s0++;
      end
    end
    idle_inputs();
    n_vec++; if (s1 !== 3) begin n_err++; $display("FAIL bp_req1_count got %0d exp 3", s1); end
    n_vec++; if (s0 !== 6) begin n_err++; $display("FAIL bp_req0_count got %0d exp 6", s0); end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    valid0 = 1'b1; wa0 = 5'd0; din0 = 32'h1; ra1 = 5'd0; ra2 = 5'd0;
    @(posedge clk); @(negedge clk);
    valid0 = 1'b0;
    n_vec++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL zero_busy1 got %b exp 0", busy1); end
    n_vec++; if (busy2 !== 1'b0) begin n_err++; $display("FAIL zero_busy2 got %b exp 0", busy2); end
    @(posedge clk); @(negedge clk);
    n_vec++; if (we !== 1'b0) begin n_err++; $display("FAIL zero_we got %b exp 0", we); end
    n_vec++; if (wa !== 5'd0) begin n_err++; $display("FAIL zero_wa got %0d exp 0", wa); end
    n_vec++; if (din !== 32'h1) begin n_err++; $display("FAIL zero_din got %h exp 1", din); end
    n_vec++; if (ready0 !== 1'b1) begin n_err++; $display("FAIL zero_ready0 got %b exp 1", ready0); end
  endtask

  task automatic test_reset_midstream();
    int leaks;
    leaks = 0;
    do_reset();
    ra1 = 5'd10;
    valid0 = 1'b1; wa0 = 5'd9;  din0 = 32'h9;
    valid1 = 1'b1; wa1 = 5'd10; din1 = 32'hA;
    @(posedge clk); @(negedge clk);
    wa0 = 5'd17; din0 = 32'h17; wa1 = 5'd18; din1 = 32'h18;
    @(posedge clk); @(negedge clk);
    n_vec++; if (we !== 1'b1 || wa !== 5'd9) begin n_err++; $display("FAIL mid_prefill got we=%b wa=%0d exp 1/9", we, wa); end
    n_vec++; if (busy1 !== 1'b1) begin n_err++; $display("FAIL mid_busy_before got %b exp 1", busy1); end
    rst = 1'b1; valid0 = 1'b0; valid1 = 1'b0;
    @(posedge clk); @(negedge clk);
    n_vec++; if (we !== 1'b0) begin n_err++; $display("FAIL mid_we_reset got %b exp 0", we); end
    n_vec++; if (ready0 !== 1'b0 || ready1 !== 1'b0) begin n_err++; $display("FAIL mid_ready_in_reset got %b%b exp 00", ready0, ready1); end
    n_vec++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL mid_busy_in_reset got %b exp 0", busy1); end
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    n_vec++; if (ready0 !== 1'b1 || ready1 !== 1'b1) begin n_err++; $display("FAIL mid_ready_after got %b%b exp 11", ready0, ready1); end
    n_vec++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL mid_busy_after got %b exp 0", busy1); end
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); @(negedge clk);
      if (we !== 1'b0) leaks++;
    end
    n_vec++; if (leaks !== 0) begin n_err++; $display("FAIL mid_no_leak got %0d writes exp 0", leaks); end
    idle_inputs();
  endtask

  task automatic test_wrap();
    logic [31:0] exp_d [10];
    int i0, seen;
    logic acc0;
    i0 = 0; seen = 0;
    for (int k = 0; k < 10; k++) exp_d[k] = $urandom;
    @(negedge clk);
    for (int c = 0; c < 14; c++) begin
      valid0 = (i0 < 10);
      wa0    = 5'(1 + (i0 % 10));
      din0   = exp_d[i0 % 10];
      #1;
      acc0 = valid0 && ready0;
      if (valid0) begin
        n_vec++; if (ready0 !== 1'b1) begin n_err++; $display("FAIL wrap_ready0[%0d] got %b exp 1", c, ready0); end
      end
      @(posedge clk);
      if (acc0) i0++;
      @(negedge clk);
      if (we === 1'b1 && seen < 10) begin
        n_vec++; if (wa !== 5'(seen + 1) || din !== exp_d[seen]) begin
          n_err++; $display("FAIL wrap_entry[%0d] got %0d/%h exp %0d/%h", seen, wa, din, seen + 1, exp_d[seen]);
        end
        seen++;
      end
    end
    idle_inputs();
    n_vec++; if (seen !== 10) begin n_err++; $display("FAIL wrap_count got %0d exp 10", seen); end
  endtask

  task automatic test_random();
    logic [36:0] q0 [$];
    logic [36:0] q1 [$];
    logic [36:0] e;
    logic m_we, m_last, e_r0, e_r1, e_b1, e_b2, acc0, acc1, hold0, hold1, g;
    logic [4:0]  m_wa;
    logic [31:0] m_din;
    do_reset();
    m_we = 1'b0; m_wa = '0; m_din = '0; m_last = 1'b1;
    hold0 = 1'b0; hold1 = 1'b0;
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      if (!hold0) begin valid0 = ($urandom_range(0, 3) != 0); wa0 = 5'($urandom_range(0, 3)); din0 = $urandom; end
      if (!hold1) begin valid1 = ($urandom_range(0, 3) != 0); wa1 = 5'($urandom_range(0, 3)); din1 = $urandom; end
      ra1 = 5'($urandom_range(0, 3));
      ra2 = 5'($urandom_range(0, 3));
      e_r0 = !rst && (q0.size() < int'(DEPTH));
      e_r1 = !rst && (q1.size() < int'(DEPTH));
      e_b1 = m_we && (m_wa == ra1);
      e_b2 = m_we && (m_wa == ra2);
      foreach (q0[j]) begin if (q0[j][36:32] == ra1) e_b1 = 1'b1; if (q0[j][36:32] == ra2) e_b2 = 1'b1; end
      foreach (q1[j]) begin if (q1[j][36:32] == ra1) e_b1 = 1'b1; if (q1[j][36:32] == ra2) e_b2 = 1'b1; end
      e_b1 = e_b1 && !rst && (ra1 != 5'd0);
      e_b2 = e_b2 && !rst && (ra2 != 5'd0);
      #1;
      n_vec++; if (ready0 !== e_r0) begin n_err++; $display("FAIL rand_ready0 c=%0d got %b exp %b", c, ready0, e_r0); end
      n_vec++; if (ready1 !== e_r1) begin n_err++; $display("FAIL rand_ready1 c=%0d got %b exp %b", c, ready1, e_r1); end
      n_vec++; if (we !== m_we) begin n_err++; $display("FAIL rand_we c=%0d got %b exp %b", c, we, m_we); end
      n_vec++; if (wa !== m_wa) begin n_err++; $display("FAIL rand_wa c=%0d got %0d exp %0d", c, wa, m_wa); end
      n_vec++; if (din !== m_din) begin n_err++; $display("FAIL rand_din c=%0d got %h exp %h", c, din, m_din); end
      n_vec++; if (busy1 !== e_b1) begin n_err++; $display("FAIL rand_busy1 c=%0d got %b exp %b", c, busy1, e_b1); end
      n_vec++; if (busy2 !== e_b2) begin n_err++; $display("FAIL rand_busy2 c=%0d got %b exp %b", c, busy2, e_b2); end
      acc0 = valid0 && e_r0;
      acc1 = valid1 && e_r1;
      @(posedge clk);
      if (rst) begin
        q0.delete(); q1.delete();
        m_we = 1'b0; m_wa = '0; m_din = '0; m_last = 1'b1;
      end else begin
        if (q0.size() != 0 || q1.size() != 0) begin
          g = (q0.size() != 0 && q1.size() != 0) ? !m_last : (q0.size() == 0);
          e = g ? q1.pop_front() : q0.pop_front();
          m_we = (e[36:32] != 5'd0); m_wa = e[36:32]; m_din = e[31:0]; m_last = g;
        end else begin
          m_we = 1'b0;
        end
        if (acc0) q0.push_back({wa0, din0});
        if (acc1) q1.push_back({wa1, din1});
      end
      hold0 = valid0 && !acc0 && !rst;
      hold1 = valid1 && !acc1 && !rst;
      @(negedge clk);
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single_write();
    test_contention();
    test_backpressure();
    test_zero_reg();
    test_reset_midstream();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rf_wr_arbiter.md
RF_WR_ARBITER -- requirements
Module: rf_wr_arbiter

Interface
REQ-001 The block SHALL have one parameter, DEPTH, default 2: entries per requester queue; a power of two, at least 2.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port valid0, input, 1 bit: requester 0 (pipeline writeback) offers a write.
REQ-005 The block SHALL have port wa0, input, 5 bits: requester 0 destination register.
REQ-006 The block SHALL have port din0, input, 32 bits: requester 0 write data.
REQ-007 The block SHALL have port ready0, output, 1 bit: requester 0 queue can accept.
REQ-008 The block SHALL have ports valid1, wa1, din1 and ready1, identical in width and meaning to REQ-004..007, for requester 1 (multi-cycle unit).
REQ-009 The block SHALL have ports we, wa and din, outputs of 1, 5 and 32 bits: registered drive to the regfile write port.
REQ-010 The block SHALL have ports ra1 and ra2, inputs, 5 bits each: read addresses to check.
REQ-011 The block SHALL have ports busy1 and busy2, outputs, 1 bit each: a pending write targets ra1 or ra2 respectively.

Function
REQ-012 Each requester SHALL own an in-order FIFO of DEPTH entries holding {addr, data}.
REQ-013 An entry SHALL be pushed at a clk edge where validN=1 and readyN=1.
REQ-014 readyN SHALL equal (queue count != DEPTH) and SHALL depend only on registered state, never on the same-cycle pop.
REQ-015 A full queue SHALL ignore validN, and the requester SHALL hold its data until ready.
REQ-016 There SHALL be no bypass: a pushed entry spends at least one cycle in its queue.
REQ-017 Each cycle, the arbiter SHALL grant at most one non-empty queue head.
REQ-018 When both queues are non-empty, the arbiter SHALL grant the queue not granted last (round-robin via a last_grant bit).
REQ-019 When exactly one queue is non-empty, the arbiter SHALL grant that queue.
REQ-020 Every grant, including a single-requester grant, SHALL update last_grant.
REQ-021 A granted head SHALL be popped at the edge, and we, wa and din SHALL load {wa!=0, head addr, head data}.
REQ-022 With no grant, we SHALL load 0, while wa and din hold their previous values.
REQ-023 Writes to register 0 SHALL be accepted, queued and popped normally, but SHALL issue we=0.
REQ-024 Latency: an entry pushed at edge N with no contention SHALL show we=1 after edge N+1, and the regfile SHALL capture it at edge N+2.
REQ-025 Under continuous contention, each requester SHALL receive a grant at least every 2 cycles.
REQ-026 Push and pop on the same queue in one cycle SHALL leave its count unchanged.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH.
REQ-028 busyK SHALL be combinational: 1 iff raK!=0 and (any valid entry in either queue has addr==raK, or (we=1 and wa==raK)).
REQ-029 busyK SHALL clear in the cycle after the regfile captures the last matching write.
REQ-030 busyK SHALL be 0 for raK=0.
REQ-031 Order within one requester SHALL be preserved.
REQ-032 Order across requesters to the same register SHALL follow grant order.

Reset
REQ-033 While rst=1 at an edge, both queues SHALL empty, we=0, wa=0, din=0, last_grant=1 (requester 0 wins the first tie), and pushes SHALL be ignored.
REQ-034 ready0, ready1, busy1 and busy2 SHALL be 0 while rst=1.
REQ-035 A reset mid-operation SHALL discard all queued and output-stage writes; none SHALL reach the regfile afterwards.

Verification
REQ-036 Single write: valid0 for one cycle with wa0=5, din0=0xDEADBEEF -> we=1, wa=5, din=0xDEADBEEF exactly 2 edges after push; busy1 (ra1=5) is 1 from the cycle after the push through the cycle we=1, then 0.
REQ-037 Contention: both requesters stream 4 writes (r1..r4 vs r11..r14) from the cycle after reset -> we sequence r1, r11, r2, r12, ...; no gaps once both queues are non-empty.
REQ-038 Backpressure: requester 1 pushes 3 entries while requester 0 keeps its queue non-empty -> ready1=0 after DEPTH=2 entries; third accepted only after a pop; all 3 written in order.
REQ-039 Zero register: push wa0=0, din0=0x1 -> popped on schedule with we=0; busy for ra=0 always 0.
REQ-040 Reset mid-stream: assert rst for 1 cycle with 2 entries queued and we=1 -> we=0 after that edge; the queued entries never appear on we; ready0=ready1=1 the cycle after rst deasserts.
REQ-041 Wrap: 10 back-to-back writes on requester 0 alone -> all 10 appear in order with correct data; pointers wrap without loss.
